// File: rtl/simon_round_ctrl.sv
// Round sequencer for the Simon Says game: two timed pattern entries, a compare step,
// and a held win/lose verdict driving the turn, status, countdown and LED outputs.
module simon_round_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_SECS    = 9,
  parameter int unsigned PAT_W         = 8
) (
  input  logic             cin,
  input  logic             reset,
  input  logic             start,
  input  logic             commit,
  input  logic [PAT_W-1:0] sw,
  output logic             turn,
  output logic [1:0]       status,
  output logic [3:0]       seconds,
  output logic [PAT_W-1:0] sw_leds,
  output logic             busy
);

  localparam int unsigned    TickW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     SecsInit   = 4'(ROUND_SECS);

  localparam logic [1:0] StatusNeutral = 2'b00;
  localparam logic [1:0] StatusLose    = 2'b01;
  localparam logic [1:0] StatusWin     = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StGap,
    StP2,
    StCmp,
    StResult
  } state_e;

  state_e           state_q;
  logic [PAT_W-1:0] pat1_q;
  logic [PAT_W-1:0] pat2_q;
  logic [TickW-1:0] tick_q;
  logic             start_q;
  logic             commit_q;

  logic             start_rise;
  logic             commit_rise;
  logic             wrap;
  logic             entry_done;
  logic [TickW-1:0] tick_next;
  logic [3:0]       secs_next;

  assign start_rise  = start & ~start_q;
  assign commit_rise = commit & ~commit_q;
  assign wrap        = (tick_q == TickLast);
  // Time runs out on the wrap that takes the digit from 1 to 0.
  assign entry_done  = commit_rise | (wrap & (seconds == 4'd1));
  assign tick_next   = wrap ? '0 : tick_q + TickW'(1);

  always_comb begin
    secs_next = seconds;
    if (wrap && (seconds != 4'd0)) begin
      secs_next = seconds - 4'd1;
    end
  end

  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pat1_q   <= '0;
      pat2_q   <= '0;
      tick_q   <= '0;
      start_q  <= 1'b0;
      commit_q <= 1'b0;
      turn     <= 1'b0;
      status   <= StatusNeutral;
      seconds  <= SecsInit;
      sw_leds  <= '0;
      busy     <= 1'b0;
    end else begin
      start_q  <= start;
      commit_q <= commit;

      unique case (state_q)
        StIdle, StResult: begin
          sw_leds <= '0;
          if (start_rise) begin
            state_q <= StP1;
            pat1_q  <= '0;
            pat2_q  <= '0;
            tick_q  <= '0;
            seconds <= SecsInit;
            status  <= StatusNeutral;
            turn    <= 1'b0;
            busy    <= 1'b1;
          end
        end

        StP1: begin
          pat1_q  <= pat1_q | sw;
          tick_q  <= tick_next;
          seconds <= secs_next;
          if (entry_done) begin
            state_q <= StGap;
            turn    <= 1'b1;
            sw_leds <= '0;
          end else begin
            sw_leds <= sw;
          end
        end

        // Hold here until every switch is down so player 1's entry cannot leak into pat2.
        StGap: begin
          sw_leds <= '0;
          seconds <= SecsInit;
          tick_q  <= '0;
          if (sw == '0) begin
            state_q <= StP2;
          end
        end

        StP2: begin
          pat2_q  <= pat2_q | sw;
          tick_q  <= tick_next;
          seconds <= secs_next;
          if (entry_done) begin
            state_q <= StCmp;
            sw_leds <= '0;
          end else begin
            sw_leds <= sw;
          end
        end

        StCmp: begin
          status  <= (pat1_q == pat2_q) ? StatusWin : StatusLose;
          busy    <= 1'b0;
          sw_leds <= '0;
          state_q <= StResult;
        end

        default: begin
          state_q <= StIdle;
          turn    <= 1'b0;
          busy    <= 1'b0;
          sw_leds <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl with a 4-tick second and a 3-second countdown.
module tb_simon_round_ctrl;

  logic       cin = 1'b0;
  logic       reset;
  logic       start;
  logic       commit;
  logic [7:0] sw;
  logic       turn;
  logic [1:0] status;
  logic [3:0] seconds;
  logic [7:0] sw_leds;
  logic       busy;

  int tests = 0;
  int fails = 0;

  simon_round_ctrl #(
    .TICKS_PER_SEC(4),
    .ROUND_SECS   (3),
    .PAT_W        (8)
  ) dut (
    .cin    (cin),
    .reset  (reset),
    .start  (start),
    .commit (commit),
    .sw     (sw),
    .turn   (turn),
    .status (status),
    .seconds(seconds),
    .sw_leds(sw_leds),
    .busy   (busy)
  );

  always #5 cin = ~cin;

  task automatic cyc();
    @(posedge cin);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int t, input int st, input int sec,
                         input int b);
    chk({tag, ".turn"}, 32'(turn), t);
    chk({tag, ".status"}, 32'(status), st);
    chk({tag, ".seconds"}, 32'(seconds), sec);
    chk({tag, ".busy"}, 32'(busy), b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; commit = 1'b0; sw = 8'h00;
    cyc(); cyc();
    chk_out("rst", 0, 0, 3, 0);
    chk("rst.leds", 32'(sw_leds), 0);
    reset = 1'b0;
    cyc();
    chk_out("idle", 0, 0, 3, 0);

    // Full-length round with no switches raised.
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("t1.p1_entry", 0, 0, 3, 1);
    for (int i = 1; i < 12; i++) begin
      cyc();
      chk_out("t1.p1", 0, 0, 3 - i / 4, 1);
    end
    cyc(); chk_out("t1.gap", 1, 0, 0, 1);
    cyc(); chk_out("t1.p2_entry", 1, 0, 3, 1);
    repeat (11) cyc();
    chk_out("t1.p2_last", 1, 0, 1, 1);
    cyc(); chk_out("t1.cmp", 1, 0, 0, 1);
    cyc(); chk_out("t1.result", 1, 3, 0, 0);

    // Matching A5 patterns, both ended by commit.
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("t2.p1", 0, 0, 3, 1);
    sw = 8'hA5; cyc();
    chk("t2.leds", 32'(sw_leds), 'hA5);
    sw = 8'h00; cyc();
    commit = 1'b1; cyc(); commit = 1'b0;
    chk_out("t2.gap", 1, 0, 3, 1);
    chk("t2.gap_leds", 32'(sw_leds), 0);
    cyc(); chk_out("t2.p2", 1, 0, 3, 1);
    sw = 8'hA5; cyc();
    sw = 8'h00; commit = 1'b1; cyc(); commit = 1'b0;
    chk_out("t2.cmp", 1, 0, 3, 1);
    cyc(); chk_out("t2.result", 1, 3, 3, 0);
    chk("t2.result_leds", 32'(sw_leds), 0);

    // Sticky OR: 0E then 01 rebuilds 0F.
    start = 1'b1; cyc(); start = 1'b0;
    sw = 8'h0F; cyc();
    sw = 8'h00; commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    sw = 8'h0E; cyc();
    sw = 8'h01; cyc();
    sw = 8'h00; commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    chk("t3a.status", 32'(status), 3);

    start = 1'b1; cyc(); start = 1'b0;
    sw = 8'h0F; cyc();
    sw = 8'h00; commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    sw = 8'h1F; cyc();
    sw = 8'h00; commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    chk_out("t3b.result", 1, 1, 3, 0);

    // Restart straight out of a losing result.
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("res_restart", 0, 0, 3, 1);

    // Commit lands on the final wrap of P1.
    repeat (11) cyc();
    chk("t4.last_sec", 32'(seconds), 1);
    commit = 1'b1; cyc(); commit = 1'b0;
    chk_out("t4.exit", 1, 0, 0, 1);
    cyc(); chk_out("t4.p2", 1, 0, 3, 1);
    cyc(); chk_out("t4.p2b", 1, 0, 3, 1);
    commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    chk("t4.status", 32'(status), 3);

    // Switch still up at end of P1 keeps the block in GAP; start is ignored there.
    start = 1'b1; cyc(); start = 1'b0;
    sw = 8'h01; cyc();
    chk("t5.p1_leds", 32'(sw_leds), 1);
    commit = 1'b1; cyc(); commit = 1'b0;
    chk_out("t5.gap", 1, 0, 3, 1);
    cyc();
    chk_out("t5.gap_hold", 1, 0, 3, 1);
    chk("t5.gap_leds", 32'(sw_leds), 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("t5.gap_start", 1, 0, 3, 1);
    chk("t5.gap_start_leds", 32'(sw_leds), 0);
    cyc();
    chk("t5.gap_leds2", 32'(sw_leds), 0);
    sw = 8'h00; cyc();
    sw = 8'h02; cyc();
    chk("t5.p2_leds", 32'(sw_leds), 2);
    chk("t5.p2_turn", 32'(turn), 1);

    // Asynchronous reset in the middle of P2.
    repeat (3) cyc();
    chk("t6.secs2", 32'(seconds), 2);
    reset = 1'b1;
    #1;
    chk_out("t6.rst", 0, 0, 3, 0);
    chk("t6.rst_leds", 32'(sw_leds), 0);
    sw = 8'h00;
    cyc();
    reset = 1'b0;
    cyc();
    chk_out("t6.idle", 0, 0, 3, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("t6.p1", 0, 0, 3, 1);
    chk("t6.p1_leds", 32'(sw_leds), 0);
    repeat (4) cyc();
    chk_out("t6.p1_tick", 0, 0, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
